dcache_lsu: RTL
===============

// Module: dcache_lsu
// PURPOSE
//  Load/store front end between the memory pipeline stage and the data cache.
//  - Accepts one request at a time from the pipeline over a valid/ready handshake.
//  - Drives the dcache request port and holds it stable until hit/write-complete.
//  - Aligns load data and sign/zero-extends it; returns a response with an exception flag.
//  - Handles misaligned accesses: trap, or split into byte accesses (see CONFIGURATION).
// PARAMETERS
//  ADDR_WIDTH  64  request/dcache address width
//  DATA_WIDTH  64  data word width; byte lanes = DATA_WIDTH/8
// PORTS
//  clk              in   1   clock
//  reset            in   1   synchronous, active-high reset
//  req_valid        in   1   pipeline request valid
//  req_ready        out  1   high only in IDLE; transfer = req_valid && req_ready
//  req_addr         in   64  byte address (virtual or physical)
//  req_wdata        in   64  store data, right-justified
//  req_size         in   2   access is 2^req_size bytes
//  req_signed       in   1   load sign-extends when 1
//  req_wr           in   1   1 = store, 0 = load
//  flush            in   1   abort an in-flight load
//  virtual_mode     in   1   CSR translation mode; passed through to dcache
//  resp_valid       out  1   response available; held until resp_ready
//  resp_ready       in   1   pipeline accepts response
//  resp_data        out  64  extended load data; 0 for stores
//  resp_misalign    out  1   misaligned-access exception (trap build only)
//  dc_addr          out  64  dcache in_addr
//  dc_wdata         out  64  dcache wdata, right-justified
//  dc_wlen          out  2   dcache wlen
//  dc_enable        out  1   dcache_enable
//  dc_wrn           out  1   dcache wrn
//  dc_virtual_mode  out  1   = virtual_mode (combinational)
//  dc_rdata         in   64  full 8-byte word at dc_addr[63:3]
//  dc_valid         in   1   load hit this cycle
//  dc_write_done    in   1   store committed this cycle
// BEHAVIOUR
//  - Reset: state=IDLE; resp_valid=0, resp_data=0, resp_misalign=0, dc_enable=0; all dc_* regs=0.
//  - FSM: IDLE -> ACCESS -> RESP -> IDLE.
//  - IDLE: on transfer, latch the request and compute mis = |(addr & ((1<<size)-1)).
//    - aligned -> ACCESS.
//    - mis (trap build) -> RESP with resp_misalign=1; no dcache access.
//  - ACCESS: dc_enable=1, dc_addr/dc_wdata/dc_wlen/dc_wrn held constant.
//    - Done when dc_valid (load) or dc_write_done (store): capture extracted data, go to RESP.
//    - Data extract: shift dc_rdata right by 8*addr[2:0], keep 8*2^size bits,
//      then extend per req_signed; 64-bit loads are passed unchanged.
//    - Minimum latency: transfer cycle T, hit at T+1, resp_valid at T+2.
//    - Misses stall in ACCESS indefinitely; the dcache refills while inputs are held.
//  - RESP: resp_valid=1 and outputs stable until resp_ready, then IDLE (req_ready=1 next cycle).
//  - flush: in ACCESS with a load, go to IDLE next cycle; no response.
//    - A dc_valid in the same cycle is discarded.
//    - flush is ignored for stores and in RESP.
//  - reset mid-operation: abandon immediately; dc_enable=0 next cycle.
// CONFIGURATION
//  - LSU_MISALIGN_SPLIT_EN undefined: misaligned access traps (resp_misalign=1, resp_data=0).
//  - LSU_MISALIGN_SPLIT_EN defined: misaligned access executes as 2^size sequential byte accesses.
//    - 3-bit counter i; dc_addr = addr+i, dc_wlen=0, dc_wdata = wdata>>8i.
//    - Loads assemble byte i into bits [8i+:8], then extend.
//    - Response comes after the last byte; resp_misalign is tied 0.
//    - flush is honoured only between byte accesses of a load.
// STRUCTURE
//  - lsu_pkg: lsu_state_e {IDLE, ACCESS, RESP}; LSU_SZ_B/H/W/D localparams;
//    function is_misaligned(addr, size).
//  - Sub-module lsu_load_align (combinational): inputs rdata, byte offset, size, signed;
//    output extended data. Also used by split-mode assembly.
// TESTING
//  1. Aligned LD 0x1000, dc_valid at T+1, dc_rdata=0x8877665544332211
//     -> resp_data=0x8877665544332211 at T+2.
//  2. LB signed 0x1003, dc_rdata=0x...F0332211 -> resp_data=0xFFFFFFFFFFFFFFF0;
//     LBU -> 0x00000000000000F0.
//  3. SW 0x2004 data 0xDEADBEEF, dc_write_done after 5 miss cycles
//     -> dc_* stable throughout; resp_valid 1 cycle after write_done; resp_data=0.
//  4. LW at 0x3002: trap build -> resp_misalign=1, dc_enable never high;
//     split build -> 4 byte accesses 0x3002..0x3005, merged word returned.
//  5. LD miss, flush in 2nd stall cycle -> IDLE next cycle, no resp_valid, req_ready=1.
//  6. resp_ready held low 3 cycles -> resp_valid/resp_data stable, req_ready=0;
//     reset in ACCESS -> dc_enable=0 next cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the dcache load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    localparam logic [1:0] LSU_SZ_B = 2'd0;
    localparam logic [1:0] LSU_SZ_H = 2'd1;
    localparam logic [1:0] LSU_SZ_W = 2'd2;
    localparam logic [1:0] LSU_SZ_D = 2'd3;

    // Only the low three address bits can break natural alignment of a <=8-byte access.
    function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
        logic [2:0] mask;
        mask = 3'((4'd1 << size) - 4'd1);
        return |(addr_lo & mask);
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data aligner: selects the addressed bytes of a dcache word and sign/zero-extends them.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [2:0]            offset,
    input  logic [1:0]            size,
    input  logic                  is_signed,
    output logic [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] shifted;
    logic signed [7:0]     byte_s;
    logic signed [15:0]    half_s;
    logic signed [31:0]    word_s;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        byte_s  = shifted[7:0];
        half_s  = shifted[15:0];
        word_s  = shifted[31:0];
        case (size)
            LSU_SZ_B: data = is_signed ? DATA_WIDTH'(byte_s) : DATA_WIDTH'(shifted[7:0]);
            LSU_SZ_H: data = is_signed ? DATA_WIDTH'(half_s) : DATA_WIDTH'(shifted[15:0]);
            LSU_SZ_W: data = is_signed ? DATA_WIDTH'(word_s) : DATA_WIDTH'(shifted[31:0]);
            default:  data = shifted;
        endcase
    end

endmodule

// File: rtl/dcache_lsu.sv
// Load/store front end between the memory stage and the data cache.
// Define LSU_MISALIGN_SPLIT_EN to execute misaligned accesses as byte sequences instead of trapping.
module dcache_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic                  req_wr,
    input  logic                  flush,
    input  logic                  virtual_mode,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_misalign,
    output logic [ADDR_WIDTH-1:0] dc_addr,
    output logic [DATA_WIDTH-1:0] dc_wdata,
    output logic [1:0]            dc_wlen,
    output logic                  dc_enable,
    output logic                  dc_wrn,
    output logic                  dc_virtual_mode,
    input  logic [DATA_WIDTH-1:0] dc_rdata,
    input  logic                  dc_valid,
    input  logic                  dc_write_done
);

    lsu_state_e            state_q, state_d;
    logic [1:0]            size_q;
    logic                  signed_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic                  resp_mis_q;
    logic [ADDR_WIDTH-1:0] dc_addr_q;
    logic [DATA_WIDTH-1:0] dc_wdata_q;
    logic [1:0]            dc_wlen_q;
    logic                  dc_wrn_q;

    logic                  transfer;
    logic                  req_mis;
    logic                  acc_done;
    logic                  flush_take;
    logic                  last_acc;
    logic [DATA_WIDTH-1:0] align_data;
    logic [1:0]            align_size;
    logic                  align_signed;

    assign transfer = req_valid && (state_q == IDLE);
    assign req_mis  = is_misaligned(req_addr[2:0], req_size);
    assign acc_done = (state_q == ACCESS) && (wr_q ? dc_write_done : dc_valid);

`ifdef LSU_MISALIGN_SPLIT_EN
    logic                  split_q;
    logic [2:0]            cnt_q;
    logic [2:0]            cnt_nxt;
    logic                  last_byte;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] asm_q;
    logic [DATA_WIDTH-1:0] asm_nxt;
    logic [DATA_WIDTH-1:0] merge_data;

    assign cnt_nxt      = cnt_q + 3'd1;
    assign last_byte    = (cnt_q == 3'((4'd1 << size_q) - 4'd1));
    assign asm_nxt      = asm_q | (DATA_WIDTH'(align_data[7:0]) << {cnt_q, 3'b000});
    assign align_size   = split_q ? LSU_SZ_B : size_q;
    assign align_signed = split_q ? 1'b0 : signed_q;
    assign last_acc     = !split_q || last_byte;
    // A split load may only be abandoned at a byte boundary, never mid-sequence-word.
    assign flush_take   = flush && !wr_q && (!split_q || (acc_done && !last_byte));

    lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
        .rdata     (asm_nxt),
        .offset    (3'd0),
        .size      (size_q),
        .is_signed (signed_q),
        .data      (merge_data)
    );

    always_ff @(posedge clk) begin
        if (transfer) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            asm_q   <= '0;
        end else if (acc_done && !flush_take && split_q && !last_byte) begin
            asm_q   <= asm_nxt;
        end
    end
`else
    assign align_size   = size_q;
    assign align_signed = signed_q;
    assign last_acc     = 1'b1;
    assign flush_take   = flush && !wr_q;
`endif

    lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .rdata     (dc_rdata),
        .offset    (dc_addr_q[2:0]),
        .size      (align_size),
        .is_signed (align_signed),
        .data      (align_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (transfer) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    state_d = ACCESS;
`else
                    state_d = req_mis ? RESP : ACCESS;
`endif
                end
            end
            ACCESS: begin
                if (flush_take)
                    state_d = IDLE;
                else if (acc_done && last_acc)
                    state_d = RESP;
            end
            RESP: begin
                if (resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            size_q      <= LSU_SZ_B;
            signed_q    <= 1'b0;
            wr_q        <= 1'b0;
            resp_data_q <= '0;
            resp_mis_q  <= 1'b0;
            dc_addr_q   <= '0;
            dc_wdata_q  <= '0;
            dc_wlen_q   <= '0;
            dc_wrn_q    <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q     <= 1'b0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (transfer) begin
                size_q      <= req_size;
                signed_q    <= req_signed;
                wr_q        <= req_wr;
                resp_data_q <= '0;
                dc_addr_q   <= req_addr;
                dc_wdata_q  <= req_wdata;
                dc_wlen_q   <= req_size;
                dc_wrn_q    <= req_wr;
`ifdef LSU_MISALIGN_SPLIT_EN
                resp_mis_q  <= 1'b0;
                split_q     <= req_mis;
                cnt_q       <= '0;
                if (req_mis)
                    dc_wlen_q <= LSU_SZ_B;
`else
                resp_mis_q  <= req_mis;
`endif
            end
            if (acc_done && !flush_take) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                if (split_q && !last_byte) begin
                    cnt_q      <= cnt_nxt;
                    dc_addr_q  <= addr_q + ADDR_WIDTH'(cnt_nxt);
                    dc_wdata_q <= wdata_q >> {cnt_nxt, 3'b000};
                end else begin
                    resp_data_q <= wr_q ? '0 : (split_q ? merge_data : align_data);
                end
`else
                resp_data_q <= wr_q ? '0 : align_data;
`endif
            end
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign resp_valid      = (state_q == RESP);
    assign resp_data       = resp_data_q;
    assign resp_misalign   = resp_mis_q;
    assign dc_enable       = (state_q == ACCESS);
    assign dc_addr         = dc_addr_q;
    assign dc_wdata        = dc_wdata_q;
    assign dc_wlen         = dc_wlen_q;
    assign dc_wrn          = dc_wrn_q;
    assign dc_virtual_mode = virtual_mode;

endmodule
